pulse_train_gen: RTL

- Generates a programmable train of clean rectangular pulses on sig_out: num_pulses pulses, each high_cyc clock cycles high followed by low_cyc cycles low.
- This is the transmit side of the board's edge-based signalling. The downstream two-flop synchroniser plus edge detector on the receiving side sees exactly num_pulses rising edges and num_pulses falling edges per train.
- Used as a stimulus/source block: LED/IO strobes, loopback tests of button-edge capture logic.
- Start/busy/done handshake toward the controlling FSM.

---
 rtl/pulse_train_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable train of num_pulses rectangular pulses (H cycles high, L cycles low)
// with a start/busy/done handshake; every output is registered.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cyc,
  input  logic [CNT_W-1:0] low_cyc,
  input  logic [N_W-1:0]   num_pulses,
  output logic             sig_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] phase_cnt, phase_n;
  logic [CNT_W-1:0] h_len, h_len_n, l_len, l_len_n;
  logic [N_W-1:0]   remaining, remaining_n;
  logic             sig_n, busy_n, done_n;
  logic [CNT_W-1:0] h_eff, l_eff;

  // A zero-length phase is stretched to one cycle.
  assign h_eff = (high_cyc == '0) ? CNT_W'(1) : high_cyc;
  assign l_eff = (low_cyc == '0) ? CNT_W'(1) : low_cyc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      phase_cnt <= '0;
      remaining <= '0;
      h_len     <= '0;
      l_len     <= '0;
      sig_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_n;
      remaining <= remaining_n;
      h_len     <= h_len_n;
      l_len     <= l_len_n;
      sig_out   <= sig_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase_cnt;
    remaining_n = remaining;
    h_len_n     = h_len;
    l_len_n     = l_len;
    sig_n       = sig_out;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (num_pulses != '0) begin
            state_n     = HIGH;
            sig_n       = 1'b1;
            busy_n      = 1'b1;
            h_len_n     = h_eff;
            l_len_n     = l_eff;
            phase_n     = h_eff - CNT_W'(1);
            remaining_n = num_pulses;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_n     = IDLE;
          sig_n       = 1'b0;
          busy_n      = 1'b0;
          phase_n     = '0;
          remaining_n = '0;
        end else if (phase_cnt == '0) begin
          state_n = LOW;
          sig_n   = 1'b0;
          phase_n = l_len - CNT_W'(1);
        end else begin
          phase_n = phase_cnt - CNT_W'(1);
        end
      end

      LOW: begin
        if (abort) begin
          state_n     = IDLE;
          sig_n       = 1'b0;
          busy_n      = 1'b0;
          phase_n     = '0;
          remaining_n = '0;
        end else if (phase_cnt != '0) begin
          phase_n = phase_cnt - CNT_W'(1);
        end else if (remaining > N_W'(1)) begin
          state_n     = HIGH;
          sig_n       = 1'b1;
          phase_n     = h_len - CNT_W'(1);
          remaining_n = remaining - N_W'(1);
        end else begin
          // Last pulse has finished its trailing low phase.
          state_n     = IDLE;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          remaining_n = '0;
        end
      end

      default: begin
        state_n = IDLE;
        sig_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
